// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter (dm_arbiter).
package dm_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_BURST_MAX    = 8;
    localparam int unsigned STAT_W           = 32;

endpackage

// File: rtl/dm_arb_sat_cnt.sv
// Saturating event counter with enable; holds at all-ones instead of wrapping.
module dm_arb_sat_cnt
    import dm_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    output logic [STAT_W-1:0] o_count
);

    logic [STAT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: CPU priority, DMA steals idle slots, bounded forced DMA bursts.
// Optional statistics counters are built only when DM_ARB_STATS_EN is defined.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned BURST_MAX    = DEF_BURST_MAX,
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [AW-1:0]     dma_addr,
    input  logic [DW-1:0]     dma_wdata,
    output logic [DW-1:0]     dma_rdata,
    output logic              dma_gnt,
    output logic [AW-1:0]     dm_addr,
    output logic [DW-1:0]     dm_wdata,
    output logic              dm_we,
    input  logic [DW-1:0]     dm_rdata,
    output logic [STAT_W-1:0] stat_dma_words,
    output logic [STAT_W-1:0] stat_stall_cycles
);

    localparam int unsigned WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX);

    owner_e             r_owner;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [BURST_W-1:0] r_burst_cnt;

    logic               w_burst_word;
    logic               w_dma_sel;
    logic               w_cpu_sel;
    logic [WAIT_W-1:0]  w_wait_inc;
    logic [BURST_W-1:0] w_burst_inc;

    // A burst cycle is OWN_DMA with the DMA still asking; otherwise the cycle is CPU-priority.
    always_comb begin
        w_burst_word = (r_owner == OWN_DMA) && dma_req;
        w_dma_sel    = rst_n && (w_burst_word || (!cpu_req && dma_req));
        w_cpu_sel    = rst_n && cpu_req && !w_burst_word;
        w_wait_inc   = r_wait_cnt + 1'b1;
        w_burst_inc  = r_burst_cnt + 1'b1;
    end

    always_comb begin
        dma_gnt   = w_dma_sel;
        cpu_stall = rst_n && w_burst_word && cpu_req;
        dm_addr   = w_dma_sel ? dma_addr  : cpu_addr;
        dm_wdata  = w_dma_sel ? dma_wdata : cpu_wdata;
        dm_we     = 1'b0;
        if (w_dma_sel) begin
            dm_we = dma_we;
        end else if (w_cpu_sel) begin
            dm_we = cpu_we;
        end
    end

    assign cpu_rdata = dm_rdata;
    assign dma_rdata = dm_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner     <= OWN_CPU;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_owner)
                OWN_CPU: begin
                    if (cpu_req) begin
                        if (dma_req) begin
                            if (w_wait_inc == WAIT_LAST) begin
                                r_owner     <= OWN_DMA;
                                r_wait_cnt  <= '0;
                                r_burst_cnt <= '0;
                            end else begin
                                r_wait_cnt <= w_wait_inc;
                            end
                        end
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                OWN_DMA: begin
                    if (dma_req) begin
                        if (w_burst_inc == BURST_LAST) begin
                            r_owner     <= OWN_CPU;
                            r_burst_cnt <= '0;
                        end else begin
                            r_burst_cnt <= w_burst_inc;
                        end
                    end else begin
                        // DMA dropped out early: the CPU is served now and owns the next cycle.
                        r_owner     <= OWN_CPU;
                        r_burst_cnt <= '0;
                        r_wait_cnt  <= '0;
                    end
                end
                default: begin
                    r_owner <= OWN_CPU;
                end
            endcase
        end
    end

`ifdef DM_ARB_STATS_EN
    dm_arb_sat_cnt u_dma_words (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (dma_req && dma_gnt),
        .o_count (stat_dma_words)
    );

    dm_arb_sat_cnt u_stall_cycles (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (cpu_stall),
        .o_count (stat_stall_cycles)
    );
`else
    assign stat_dma_words    = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int SL = 4;
    localparam int BM = 8;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, dm_addr, dm_wdata, dm_rdata;
    logic        cpu_stall, dma_gnt, dm_we;
    logic [31:0] stat_dma_words, stat_stall_cycles;

    dm_arbiter #(.STARVE_LIMIT(SL), .BURST_MAX(BM), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_gnt(dma_gnt),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
        .stat_dma_words(stat_dma_words), .stat_stall_cycles(stat_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, synchronous write.
    logic [31:0] dm_mem [64];
    always @(posedge clk) if (dm_we) dm_mem[dm_addr[5:0]] <= dm_wdata;
    assign dm_rdata = dm_mem[dm_addr[5:0]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: denied-request tally and a countdown of remaining burst words.
    int          denied, burst_left;
    bit          m_dma, m_cpu, m_stall, m_we, last_stall;
    logic [31:0] m_addr, m_wdata, m_words, m_stalls;
    logic [31:0] ref_mem [64];
    bit          ref_vld [64];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("m_rst_gnt", {31'b0, dma_gnt}, 0);
            chk("m_rst_stall", {31'b0, cpu_stall}, 0);
            chk("m_rst_we", {31'b0, dm_we}, 0);
            denied = 0; burst_left = 0; m_words = 0; m_stalls = 0; last_stall = 0;
        end else begin
            m_cpu = 0; m_dma = 0;
            if (burst_left > 0 && dma_req) begin
                m_dma = 1;
                burst_left--;
            end else begin
                burst_left = 0;
                if (cpu_req) begin
                    m_cpu = 1;
                    if (dma_req) begin
                        denied++;
                        if (denied == SL) begin
                            denied = 0;
                            burst_left = BM;
                        end
                    end
                end else begin
                    denied = 0;
                    m_dma = dma_req;
                end
            end
            m_stall = m_dma && cpu_req;
            m_we    = m_dma ? dma_we : (m_cpu ? cpu_we : 1'b0);
            m_addr  = m_dma ? dma_addr : cpu_addr;
            m_wdata = m_dma ? dma_wdata : cpu_wdata;
            chk("m_gnt", {31'b0, dma_gnt}, {31'b0, m_dma});
            chk("m_stall", {31'b0, cpu_stall}, {31'b0, m_stall});
            chk("m_we", {31'b0, dm_we}, {31'b0, m_we});
            chk("m_addr", dm_addr, m_addr);
            chk("m_wdata", dm_wdata, m_wdata);
            if (m_cpu && !cpu_we && ref_vld[cpu_addr[5:0]])
                chk("m_cpu_rdata", cpu_rdata, ref_mem[cpu_addr[5:0]]);
            if (m_dma && !dma_we && ref_vld[dma_addr[5:0]])
                chk("m_dma_rdata", dma_rdata, ref_mem[dma_addr[5:0]]);
`ifdef DM_ARB_STATS_EN
            chk("m_stat_words", stat_dma_words, m_words);
            chk("m_stat_stalls", stat_stall_cycles, m_stalls);
`else
            chk("m_stat_words", stat_dma_words, 0);
            chk("m_stat_stalls", stat_stall_cycles, 0);
`endif
            if (m_we) begin
                ref_mem[m_addr[5:0]] = m_wdata;
                ref_vld[m_addr[5:0]] = 1;
            end
            if (m_dma && m_words != 32'hFFFF_FFFF) m_words = m_words + 1;
            if (m_stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
            last_stall = m_stall;
        end
    end

    task automatic set_in(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                          input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1;
    endtask

    int hits;

    initial begin
        rst_n = 0;
        set_in(1, 1, 32'h20, 32'h1, 1, 1, 32'h10, 32'h2);
        @(negedge clk);
        chk("rst_gnt", {31'b0, dma_gnt}, 0);
        chk("rst_stall", {31'b0, cpu_stall}, 0);
        chk("rst_we", {31'b0, dm_we}, 0);
        tick();
        rst_n = 1;

        // Idle-slot steal followed by a CPU readback.
        set_in(0, 0, 0, 0, 1, 1, 32'h10, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("steal_gnt", {31'b0, dma_gnt}, 1);
        chk("steal_we", {31'b0, dm_we}, 1);
        chk("steal_stall", {31'b0, cpu_stall}, 0);
        tick();
        set_in(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("steal_readback", cpu_rdata, 32'hA5A5_A5A5);
        tick();

        // Starvation for two full periods of 4 CPU + 8 DMA cycles.
        do_reset();
        set_in(1, 0, 32'h10, 0, 1, 0, 32'h11, 0);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk($sformatf("starve_gnt%0d", i), {31'b0, dma_gnt}, {31'b0, (i % 12) >= 4});
            chk($sformatf("starve_stall%0d", i), {31'b0, cpu_stall}, {31'b0, (i % 12) >= 4});
            tick();
        end
        @(negedge clk);
`ifdef DM_ARB_STATS_EN
        chk("stat_words16", stat_dma_words, 16);
        chk("stat_stalls16", stat_stall_cycles, 16);
`else
        chk("stat_words0", stat_dma_words, 0);
        chk("stat_stalls0", stat_stall_cycles, 0);
`endif
        tick();

        // Stalled CPU store must be performed exactly once, after the burst.
        do_reset();
        hits = 0;
        for (int i = 0; i < 13; i++) begin
            if (i < 4) set_in(1, 0, 32'h30, 0, 1, 1, 32'h38 + (i % 8), 32'hD000_0000 + i);
            else       set_in(1, 1, 32'h20, 32'h1234, 1, 1, 32'h38 + (i % 8), 32'hD000_0000 + i);
            @(negedge clk);
            if (i >= 4 && i < 12) chk("burst_cpu_we", {31'b0, dm_we && dm_addr == 32'h20}, 0);
            if (dm_we && dm_addr == 32'h20 && dm_wdata == 32'h1234) hits++;
            tick();
        end
        set_in(1, 0, 32'h20, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("store_once", hits, 1);
        chk("store_value", cpu_rdata, 32'h1234);
        tick();

        // Early burst end after three DMA words.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) set_in(1, 0, 32'h30, 0, 1, 1, 32'h08 + i, 32'hE000_0000 + i);
            else       set_in(1, 1, 32'h24, 32'h55, 1, 1, 32'h08 + i, 32'hE000_0000 + i);
            tick();
        end
        set_in(1, 1, 32'h24, 32'h55, 0, 0, 0, 0);
        @(negedge clk);
        chk("early_stall", {31'b0, cpu_stall}, 0);
        chk("early_gnt", {31'b0, dma_gnt}, 0);
        chk("early_we", {31'b0, dm_we}, 1);
        chk("early_addr", dm_addr, 32'h24);
        tick();
        set_in(1, 0, 32'h24, 0, 1, 0, 32'h08, 0);
        @(negedge clk);
        chk("early_next_gnt", {31'b0, dma_gnt}, 0);
        chk("early_next_stall", {31'b0, cpu_stall}, 0);
        chk("early_readback", cpu_rdata, 32'h55);
        tick();

        // Reset at burst word 5, then a fresh 4-cycle CPU window.
        do_reset();
        set_in(1, 0, 32'h30, 0, 1, 0, 32'h31, 0);
        repeat (8) tick();
        rst_n = 0;
        @(negedge clk);
        chk("midrst_gnt", {31'b0, dma_gnt}, 0);
        chk("midrst_stall", {31'b0, cpu_stall}, 0);
        chk("midrst_we", {31'b0, dm_we}, 0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_after%0d", i), {31'b0, dma_gnt}, {31'b0, i >= 4});
            tick();
        end

        // Randomized traffic; CPU inputs held while the model says the pipeline is stalled.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            if (!last_stall) begin
                cpu_req   = ($urandom_range(0, 9) < 7);
                cpu_we    = $urandom_range(0, 1) != 0;
                cpu_addr  = 32'($urandom_range(0, 63));
                cpu_wdata = $urandom;
            end
            dma_req   = ($urandom_range(0, 9) < 6);
            dma_we    = $urandom_range(0, 1) != 0;
            dma_addr  = 32'($urandom_range(0, 63));
            dma_wdata = $urandom;
            tick();
        end
        rst_n = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
